// File: rtl/pass_pkg.sv
// Shared mode encodings and counter sizing for the pass_bank inhibit gate.
package pass_pkg;

    localparam logic [1:0] MODE_DIRECT  = 2'd0;
    localparam logic [1:0] MODE_HOLDOFF = 2'd1;
    localparam logic [1:0] MODE_STICKY  = 2'd2;
    localparam logic [1:0] MODE_PULSE   = 2'd3;

    // Hold-off counter width: enough bits to hold HOLD, never less than one.
    function automatic int cnt_width(input int hold);
        int w;
        w = $clog2(hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pass_chan.sv
// One channel of the inhibit gate: hold-off counter, pass history and the
// registered pass/inhibit outputs.
module pass_chan
    import pass_pkg::*;
#(
    parameter int HOLD = 4,
    parameter int CW   = cnt_width(HOLD)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       mchg_i,
    input  logic [1:0] mode_i,
    input  logic       x_i,
    input  logic       y_i,
    output logic       f_o,
    output logic       f_d_o,
    output logic       inh_o
);

    localparam logic [CW-1:0] HOLD_C = CW'(HOLD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pass_q, pass_d;
    logic          f_q, f_d;
    logic          inh_q, inh_d;
    logic          inhibit_c, pass_c;

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (x_i) begin
            cnt_d = HOLD_C;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end

        inhibit_c = (mode_i == MODE_DIRECT) ? x_i : (x_i | (cnt_q != '0));
        pass_c    = y_i & ~inhibit_c;

        case (mode_i)
            MODE_STICKY: f_d = x_i ? 1'b0 : (f_q | pass_c);
            MODE_PULSE:  f_d = pass_c & ~pass_q;
            default:     f_d = pass_c;
        endcase
        pass_d = pass_c;

        // Clear and a mode switch both flush the output and the edge history.
        if (clear_i || mchg_i) begin
            f_d    = 1'b0;
            pass_d = 1'b0;
        end

        inh_d = x_i | (cnt_d != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            pass_q <= 1'b0;
            f_q    <= 1'b0;
            inh_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pass_q <= pass_d;
            f_q    <= f_d;
            inh_q  <= inh_d;
        end
    end

    assign f_o   = f_q;
    assign f_d_o = f_d;
    assign inh_o = inh_q;

endmodule

// File: rtl/pass_bank.sv
// Multi-channel registered inhibit gate (f = ~x & y) with run-time selectable
// hold-off, sticky and pulse behaviour.
module pass_bank
    import pass_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             clear,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] inh,
    output logic             any
);

    logic [1:0]       mode_q;
    logic             any_q;
    logic             mchg;
    logic [WIDTH-1:0] f_d;

    // A new mode only steers the channels from the edge after it is seen.
    assign mchg = (mode != mode_q);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pass_chan #(
            .HOLD (HOLD)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .clear_i (clear),
            .mchg_i  (mchg),
            .mode_i  (mode_q),
            .x_i     (x[i]),
            .y_i     (y[i]),
            .f_o     (f[i]),
            .f_d_o   (f_d[i]),
            .inh_o   (inh[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= MODE_DIRECT;
            any_q  <= 1'b0;
        end else begin
            mode_q <= mode;
            any_q  <= |f_d;
        end
    end

    assign any = any_q;

endmodule

// File: tb/tb_pass_bank.sv
// Directed scoreboard bench for pass_bank (WIDTH=8, HOLD=4).
module tb_pass_bank;

    logic       clk;
    logic       reset;
    logic [1:0] mode;
    logic       clear;
    logic [7:0] x, y;
    logic [7:0] f, inh;
    logic       any;

    int tests;
    int fails;

    logic [7:0] q_f[$];
    logic [7:0] q_inh[$];
    string      q_tag[$];

    pass_bank #(.WIDTH(8), .HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .clear (clear),
        .x     (x),
        .y     (y),
        .f     (f),
        .inh   (inh),
        .any   (any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
        $fatal(1, "watchdog expired");
    end

    task automatic check_out();
        logic [7:0] ef, ei;
        string      tag;
        if (q_f.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_empty: got f=%h, required an expected entry", f);
            return;
        end
        ef  = q_f.pop_front();
        ei  = q_inh.pop_front();
        tag = q_tag.pop_front();
        tests++;
        assert (f === ef) else begin
            fails++;
            $error("FAIL %s.f: got %h, required %h", tag, f, ef);
        end
        tests++;
        assert (inh === ei) else begin
            fails++;
            $error("FAIL %s.inh: got %h, required %h", tag, inh, ei);
        end
        tests++;
        assert (any === (|ef)) else begin
            fails++;
            $error("FAIL %s.any: got %b, required %b", tag, any, |ef);
        end
    endtask

    // Drive one cycle of inputs, record the expected post-edge outputs, then
    // compare just after the edge.
    task automatic step(input logic r, input logic c, input logic [1:0] m,
                        input logic [7:0] xv, input logic [7:0] yv,
                        input logic [7:0] ef, input logic [7:0] ei,
                        input string tag);
        reset = r;
        clear = c;
        mode  = m;
        x     = xv;
        y     = yv;
        q_f.push_back(ef);
        q_inh.push_back(ei);
        q_tag.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1; clear = 1'b0; mode = 2'd0; x = 8'h00; y = 8'hFF;

        // reset, then release with everything requesting
        step(1, 0, 2'd0, 8'h00, 8'hFF, 8'h00, 8'h00, "reset0");
        step(1, 0, 2'd0, 8'h00, 8'hFF, 8'h00, 8'h00, "reset1");
        step(0, 0, 2'd0, 8'h00, 8'hFF, 8'hFF, 8'h00, "rst_release");

        // DIRECT truth table; counters still run and show on inh
        step(0, 0, 2'd0, 8'h0F, 8'h33, 8'h30, 8'h0F, "direct_mix");
        step(0, 0, 2'd0, 8'hFF, 8'h33, 8'h00, 8'hFF, "direct_allx");
        step(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'hFF, "direct_drain3");
        step(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'hFF, "direct_drain2");
        step(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'hFF, "direct_drain1");
        step(0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, "direct_drain0");

        // HOLDOFF: x[0] for one cycle with y[0] held high
        step(0, 0, 2'd1, 8'h00, 8'h01, 8'h00, 8'h00, "ho_mchg");
        step(0, 0, 2'd1, 8'h01, 8'h01, 8'h00, 8'h01, "ho_edge0");
        step(0, 0, 2'd1, 8'h00, 8'h01, 8'h00, 8'h01, "ho_edge1");
        step(0, 0, 2'd1, 8'h00, 8'h01, 8'h00, 8'h01, "ho_edge2");
        step(0, 0, 2'd1, 8'h00, 8'h01, 8'h00, 8'h01, "ho_edge3");
        step(0, 0, 2'd1, 8'h00, 8'h01, 8'h00, 8'h00, "ho_edge4");
        step(0, 0, 2'd1, 8'h00, 8'h01, 8'h01, 8'h00, "ho_edge5");

        // STICKY: latch on y pulse, release with x
        step(0, 0, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00, "st_mchg");
        step(0, 0, 2'd2, 8'h00, 8'h04, 8'h04, 8'h00, "st_set");
        step(0, 0, 2'd2, 8'h00, 8'h00, 8'h04, 8'h00, "st_hold1");
        step(0, 0, 2'd2, 8'h00, 8'h00, 8'h04, 8'h00, "st_hold2");
        step(0, 0, 2'd2, 8'h04, 8'h00, 8'h00, 8'h04, "st_xrel");
        step(0, 0, 2'd2, 8'h00, 8'h00, 8'h00, 8'h04, "st_wait3");
        step(0, 0, 2'd2, 8'h00, 8'h00, 8'h00, 8'h04, "st_wait2");
        step(0, 0, 2'd2, 8'h00, 8'h00, 8'h00, 8'h04, "st_wait1");
        step(0, 0, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00, "st_wait0");
        // STICKY again, released by clear
        step(0, 0, 2'd2, 8'h00, 8'h04, 8'h04, 8'h00, "st_set2");
        step(0, 0, 2'd2, 8'h00, 8'h00, 8'h04, 8'h00, "st_hold3");
        step(0, 1, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00, "st_clear");
        step(0, 0, 2'd2, 8'h00, 8'h00, 8'h00, 8'h00, "st_after_clr");

        // mode change out of a latched STICKY state
        step(0, 0, 2'd2, 8'h00, 8'h05, 8'h05, 8'h00, "mc_latch");
        step(0, 0, 2'd2, 8'h00, 8'h00, 8'h05, 8'h00, "mc_held");
        step(0, 0, 2'd0, 8'h00, 8'h05, 8'h00, 8'h00, "mc_flush");
        step(0, 0, 2'd0, 8'h01, 8'h05, 8'h04, 8'h01, "mc_direct");
        step(0, 0, 2'd0, 8'h00, 8'h05, 8'h05, 8'h01, "mc_direct_nocnt");

        // clear together with x in HOLDOFF: no hold-off afterwards
        step(0, 0, 2'd1, 8'h00, 8'h00, 8'h00, 8'h01, "cx_mchg");
        step(0, 1, 2'd1, 8'h01, 8'h01, 8'h00, 8'h01, "cx_clear_x");
        step(0, 0, 2'd1, 8'h00, 8'h01, 8'h01, 8'h00, "cx_nohold");

        // PULSE: one pulse per rising edge of the pass term
        step(0, 0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, "pu_mchg");
        step(0, 0, 2'd3, 8'h00, 8'h80, 8'h80, 8'h00, "pu_rise1");
        for (int i = 0; i < 9; i++)
            step(0, 0, 2'd3, 8'h00, 8'h80, 8'h00, 8'h00, "pu_held");
        step(0, 0, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00, "pu_drop");
        step(0, 0, 2'd3, 8'h00, 8'h80, 8'h80, 8'h00, "pu_rise2");
        step(0, 0, 2'd3, 8'h00, 8'h80, 8'h00, 8'h00, "pu_held2");

        tests++;
        assert (q_f.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain: %0d entries left, required 0", q_f.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
